imem_loader: RTL and testbench

- Boot loader that writes the processor's instruction memory, which the processor itself only reads.
- Accepts a byte stream over a valid/ready handshake from a UART receiver or testbench.
- Packs the bytes into big-endian 32-bit MIPS words and writes them sequentially from word address 0.
- Holds the processor halted until the image has loaded.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_word_assembler.sv | 33 +++
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W    = 5;
    localparam int IMEM_DEPTH     = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WR,
        CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master: the loader side; slave: the byte source / memory side.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_word_assembler.sv
// Packs accepted bytes MSB-first into a 32-bit word; word_full marks the
// cycle on which the last byte of a word is being accepted.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  data_byte,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_full
);
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0] byte_idx;

    assign word_full = accept && (byte_idx == LAST_IDX);

    // Shift register and byte index; word is kept across clears so the
    // last written value stays visible on the memory data bus.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (accept) begin
            word     <= {word[23:0], data_byte};
            byte_idx <= byte_idx + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: length byte, then N big-endian words written from address 0,
// processor held in halt until the image is in.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   LEN   | waiting for the word-count byte
//   DATA  | collecting the four bytes of a word
//   WR    | single write strobe for the assembled word
//   CHK   | waiting for the checksum byte (checksum build only)
//   DONE  | image loaded, processor released
//   ERR   | load aborted, processor halted
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.master     bus,
    output logic              cpu_halt,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_nxt;
    logic              accept;
    logic              load_start;
    logic              word_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign accept     = bus.rx_valid && bus.rx_ready;
    assign load_start = start && (state == IDLE || state == DONE || state == ERR);
    assign count_nxt  = words_loaded + (ADDR_W + 1)'(1);

    assign bus.rx_ready = (state == LEN) || (state == DATA) || (state == CHK);
    assign bus.mem_we   = (state == WR);
    assign bus.mem_addr = addr_q;
    assign done         = (state == DONE);
    assign err          = (state == ERR);
    assign cpu_halt     = (state != DONE);

    imem_word_assembler u_asm (
        .clock     (clock),
        .reset     (reset),
        .data_byte (bus.rx_data),
        .accept    (accept && (state == DATA)),
        .clear     (load_start),
        .word      (bus.mem_wdata),
        .word_full (word_full)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = LEN;
            LEN: begin
                if (accept) begin
                    if (bus.rx_data == 8'd0 || bus.rx_data > DEPTH_B) state_nxt = ERR;
                    else                                             state_nxt = DATA;
                end
            end
            DATA: if (word_full) state_nxt = WR;
            WR: begin
                if (count_nxt == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: if (accept) state_nxt = (bus.rx_data == csum_q) ? DONE : ERR;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Length latch, write address, word counter and running checksum.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_q        <= '0;
            addr_q       <= '0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else if (load_start) begin
            addr_q       <= '0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            if (state == LEN && accept) len_q <= bus.rx_data[ADDR_W:0];
            if (state == WR) begin
                addr_q       <= addr_q + ADDR_W'(1);
                words_loaded <= count_nxt;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (state == DATA && accept) csum_q <= csum_q ^ bus.rx_data;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued when
// an image is issued and popped by an independent write monitor.
module tb_imem_loader;
    import imem_loader_pkg::*;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CS_BUILD = 1'b1;
`else
    localparam bit CS_BUILD = 1'b0;
`endif

    typedef struct {
        logic [IMEM_ADDR_W-1:0] addr;
        logic [31:0]            data;
    } wr_t;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic                 cpu_halt, done, err;
    logic [IMEM_ADDR_W:0] words_loaded;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         sb[$];
    logic [7:0]  img[$];

    always #5 clock = ~clock;

    imem_loader_if #(.ADDR_W(IMEM_ADDR_W)) ifc ();

    imem_loader #(.ADDR_W(IMEM_ADDR_W), .DEPTH(IMEM_DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .bus          (ifc.master),
        .cpu_halt     (cpu_halt),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (reset && ifc.mem_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(ifc.mem_we), 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(ifc.mem_addr), 32'(e.addr));
                chk("wr_data", ifc.mem_wdata, e.data);
            end
            chk("rx_ready_in_wr", 32'(ifc.rx_ready), 32'd0);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit toggle);
        int budget = 60;
        if (toggle && $urandom_range(0, 1) == 1) begin
            ifc.rx_valid = 1'b0;
            @(posedge clock); #1;
        end
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        forever begin
            @(negedge clock);
            if (ifc.rx_ready) begin
                @(posedge clock); #1;
                ifc.rx_valid = 1'b0;
                break;
            end
            budget--;
            if (budget == 0) begin
                chk("byte_accept_timeout", 32'(ifc.rx_ready), 32'd1);
                ifc.rx_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic fill_rand(input int n);
        img.delete();
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    endtask

    // Reference: a valid length 1..DEPTH yields that many big-endian words
    // at addresses 0..N-1; otherwise the load fails with nothing written.
    task automatic run_load(input logic [7:0] len_b, input bit toggle,
                            input bit bad_cs, input bit start_mid);
        bit   valid, ok;
        int   n, cyc;
        wr_t  e;
        valid = (len_b != 8'd0) && (int'(len_b) <= IMEM_DEPTH);
        n     = valid ? int'(len_b) : 0;
        ok    = valid && !(bad_cs && CS_BUILD);
        for (int w = 0; w < n; w++) begin
            e.addr = w[IMEM_ADDR_W-1:0];
            e.data = {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]};
            sb.push_back(e);
        end
        pulse_start();
        send_byte(len_b, toggle);
        if (valid) begin
            for (int i = 0; i < 4 * n; i++) begin
                send_byte(img[i], toggle);
                if (start_mid && i == 1) pulse_start();
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            begin
                logic [7:0] cs;
                cs = 8'h00;
                for (int i = 0; i < 4 * n; i++) cs ^= img[i];
                if (bad_cs) cs ^= 8'h01;
                send_byte(cs, toggle);
            end
`endif
        end
        cyc = 0;
        while (!(done || err) && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        chk("done", 32'(done), 32'(ok));
        chk("err", 32'(err), 32'(!ok));
        chk("cpu_halt", 32'(cpu_halt), 32'(!ok));
        chk("words_loaded", 32'(words_loaded), 32'(n));
        chk("writes_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"},     32'(ifc.rx_ready), 32'd0);
        chk({tag, "_mem_we"},       32'(ifc.mem_we), 32'd0);
        chk({tag, "_mem_addr"},     32'(ifc.mem_addr), 32'd0);
        chk({tag, "_mem_wdata"},    ifc.mem_wdata, 32'd0);
        chk({tag, "_cpu_halt"},     32'(cpu_halt), 32'd1);
        chk({tag, "_done"},         32'(done), 32'd0);
        chk({tag, "_err"},          32'(err), 32'd0);
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        wr_t e;
        ifc.rx_data  = 8'h00;
        ifc.rx_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clock); #1;

        // Reference image, valid held high, then with random gaps.
        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        run_load(8'd2, 1'b0, 1'b0, 1'b0);
        run_load(8'd2, 1'b1, 1'b0, 1'b0);

        // Bytes offered while DONE must not be consumed.
        ifc.rx_data  = 8'hFF;
        ifc.rx_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        ifc.rx_valid = 1'b0;
        chk("idle_done_kept", 32'(done), 32'd1);
        chk("idle_count_kept", 32'(words_loaded), 32'd2);

        // Bad lengths, then recovery with a single word.
        img.delete();
        run_load(8'd0, 1'b0, 1'b0, 1'b0);
        run_load(8'd33, 1'b0, 1'b0, 1'b0);
        fill_rand(1);
        run_load(8'd1, 1'b0, 1'b0, 1'b0);

        // start during DATA is ignored.
        fill_rand(2);
        run_load(8'd2, 1'b0, 1'b0, 1'b1);

        // Random images, random gaps, random invalid lengths.
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, 8);
            fill_rand(n);
            run_load(8'(n), bit'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        img.delete();
        run_load(8'($urandom_range(33, 255)), 1'b0, 1'b0, 1'b0);
        fill_rand(IMEM_DEPTH);
        run_load(8'(IMEM_DEPTH), 1'b0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_load(8'd1, 1'b0, 1'b0, 1'b0);
        run_load(8'd1, 1'b0, 1'b1, 1'b0);
`endif

        // Reset after six data bytes of a two-word load: only word 0 lands.
        fill_rand(2);
        e.addr = '0;
        e.data = {img[0], img[1], img[2], img[3]};
        sb.push_back(e);
        pulse_start();
        send_byte(8'd2, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        chk("midload_writes_pending", 32'(sb.size()), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Loader still works after the abort.
        fill_rand(1);
        run_load(8'd1, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
